// File: rtl/fifo_arb_pkg.sv
// Shared types and width helpers for the FIFO write-port arbiter.
package fifo_arb_pkg;

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      BURST = 1'b1
   } arb_state_t;

   // Never returns 0, so a one-element range still yields a legal vector.
   function automatic int unsigned idx_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   localparam int unsigned DEF_NUM_REQ   = 4;
   localparam int unsigned DEF_BURST_LEN = 4;
   localparam int unsigned DEF_GRANT_W   = idx_width(DEF_NUM_REQ);
   localparam int unsigned DEF_BEAT_W    = idx_width(DEF_BURST_LEN + 1);

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Round-robin picker: first asserted request at or above ptr, wrapping modulo N.
module rr_pick
   import fifo_arb_pkg::*;
#(
   parameter int unsigned N = 4,
   parameter int unsigned W = idx_width(N)
) (
   input  logic [N-1:0] req,
   input  logic [W-1:0] ptr,
   output logic [W-1:0] pick,
   output logic         any_valid
);

   logic [2*N-1:0] dbl;
   logic [N-1:0]   rot;
   logic [W-1:0]   off;
   logic [W:0]     sum;

   always_comb begin
      dbl = {req, req} >> ptr;
      rot = dbl[N-1:0];
      off = '0;
      // Scan downward so the lowest rotated index wins.
      for (int unsigned i = N; i > 0; i--) begin
         if (rot[i-1]) off = W'(i - 1);
      end
      sum = {1'b0, ptr} + {1'b0, off};
      if (sum >= (W+1)'(N)) sum = sum - (W+1)'(N);
      pick      = sum[W-1:0];
      any_valid = |req;
   end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin, burst-bounded arbiter sharing the async FIFO write port among NUM_REQ requesters.
module fifo_wr_arbiter
   import fifo_arb_pkg::*;
#(
   parameter int unsigned NUM_REQ    = 4,
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned BURST_LEN  = 4
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic [NUM_REQ-1:0]              req_valid,
   input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_data,
   output logic [NUM_REQ-1:0]              req_ready,
   input  logic                            fifo_full,
   output logic                            fifo_wr_en,
   output logic [DATA_WIDTH-1:0]           fifo_din,
   output logic [$clog2(NUM_REQ)-1:0]      grant_id,
   output logic                            grant_active
);

   localparam int unsigned GRANT_W = idx_width(NUM_REQ);
   localparam int unsigned BEAT_W  = idx_width(BURST_LEN + 1);
   localparam logic [BEAT_W-1:0]  LAST_BEAT = BEAT_W'(BURST_LEN - 1);
   localparam logic [GRANT_W-1:0] LAST_REQ  = GRANT_W'(NUM_REQ - 1);

   arb_state_t          state_q, state_d;
   logic [GRANT_W-1:0]  grant_q, grant_d;
   logic [GRANT_W-1:0]  rr_ptr_q, rr_ptr_d;
   logic [BEAT_W-1:0]   beat_cnt_q, beat_cnt_d;
   logic [GRANT_W-1:0]  pick;
   logic [GRANT_W-1:0]  next_ptr;
   logic                any_valid;

   rr_pick #(
      .N (NUM_REQ),
      .W (GRANT_W)
   ) u_rr_pick (
      .req       (req_valid),
      .ptr       (rr_ptr_q),
      .pick      (pick),
      .any_valid (any_valid)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         grant_q    <= '0;
         rr_ptr_q   <= '0;
         beat_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         grant_q    <= grant_d;
         rr_ptr_q   <= rr_ptr_d;
         beat_cnt_q <= beat_cnt_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      grant_d    = grant_q;
      rr_ptr_d   = rr_ptr_q;
      beat_cnt_d = beat_cnt_q;
      req_ready  = '0;
      fifo_wr_en = 1'b0;
      fifo_din   = '0;
      next_ptr   = (grant_q == LAST_REQ) ? '0 : grant_q + GRANT_W'(1);

      case (state_q)
         IDLE: begin
            if (any_valid) begin
               grant_d    = pick;
               beat_cnt_d = '0;
               state_d    = BURST;
            end
         end
         BURST: begin
            req_ready[grant_q] = !fifo_full;
            // A dropped valid releases the grant; a full FIFO alone only stalls it.
            if (!req_valid[grant_q]) begin
               state_d  = IDLE;
               rr_ptr_d = next_ptr;
            end else if (!fifo_full) begin
               fifo_wr_en = 1'b1;
               fifo_din   = req_data[grant_q*DATA_WIDTH +: DATA_WIDTH];
               if (beat_cnt_q == LAST_BEAT) begin
                  state_d  = IDLE;
                  rr_ptr_d = next_ptr;
               end else begin
                  beat_cnt_d = beat_cnt_q + BEAT_W'(1);
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign grant_id     = grant_q;
   assign grant_active = (state_q == BURST);

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed-vector bench for fifo_wr_arbiter (NUM_REQ=4, DATA_WIDTH=8, BURST_LEN=4).
module tb_fifo_wr_arbiter;

   localparam int NR = 4;
   localparam int DW = 8;

   logic              clk = 1'b0;
   logic              rst;
   logic [NR-1:0]     req_valid;
   logic [NR*DW-1:0]  req_data;
   logic [NR-1:0]     req_ready;
   logic              fifo_full;
   logic              fifo_wr_en;
   logic [DW-1:0]     fifo_din;
   logic [1:0]        grant_id;
   logic              grant_active;

   logic [7:0] src [NR];
   int vec_cnt = 0;
   int err_cnt = 0;

   int t2_wr  [10] = '{0, 1, 1, 1, 1, 0, 1, 1, 0, 0};
   int t2_din [10] = '{0, 'h20, 'h21, 'h22, 'h23, 0, 'h24, 'h25, 0, 0};
   int t2_ga  [10] = '{0, 1, 1, 1, 1, 0, 1, 1, 1, 0};
   int t4_full[9]  = '{0, 0, 0, 1, 1, 1, 0, 0, 0};
   int t4_wr  [9]  = '{0, 1, 1, 0, 0, 0, 1, 1, 0};
   int t4_din [9]  = '{0, 'h40, 'h41, 0, 0, 0, 'h42, 'h43, 0};

   always #5 clk = ~clk;

   always_comb begin
      for (int i = 0; i < NR; i++) req_data[i*DW +: DW] = src[i];
   end

   fifo_wr_arbiter #(
      .NUM_REQ    (4),
      .DATA_WIDTH (8),
      .BURST_LEN  (4)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .req_valid    (req_valid),
      .req_data     (req_data),
      .req_ready    (req_ready),
      .fifo_full    (fifo_full),
      .fifo_wr_en   (fifo_wr_en),
      .fifo_din     (fifo_din),
      .grant_id     (grant_id),
      .grant_active (grant_active)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vec_cnt++;
      if (got !== exp) begin
         err_cnt++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Advance one clock; sources move to their next word after a handshake.
   task automatic step();
      logic [NR-1:0] hs;
      hs = req_valid & req_ready;
      check("wr_while_full", 32'(fifo_wr_en & fifo_full), 32'd0);
      check("one_hot_ready", 32'($countones(req_ready) > 1), 32'd0);
      @(negedge clk);
      for (int i = 0; i < NR; i++) if (hs[i]) src[i] = src[i] + 8'd1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      #1;
   endtask

   task automatic check_quiet(input string tag);
      check({tag, "_ready"}, 32'(req_ready), 32'd0);
      check({tag, "_wr"},    32'(fifo_wr_en), 32'd0);
      check({tag, "_din"},   32'(fifo_din), 32'd0);
      check({tag, "_gid"},   32'(grant_id), 32'd0);
      check({tag, "_ga"},    32'(grant_active), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      int p, b, r;
      rst = 1'b1;
      req_valid = '0;
      fifo_full = 1'b0;
      for (int i = 0; i < NR; i++) src[i] = 8'h00;
      #2;
      check_quiet("por");
      @(negedge clk);
      rst = 1'b0;
      #1;

      // 1: asynchronous reset mid-burst with random inputs
      req_valid = 4'hF;
      for (int i = 0; i < NR; i++) src[i] = 8'($urandom);
      #1; step();
      #1; step();
      #1;
      check("t1_pre_ga", 32'(grant_active), 32'd1);
      req_valid = 4'($urandom);
      fifo_full = 1'($urandom);
      for (int i = 0; i < NR; i++) src[i] = 8'($urandom);
      rst = 1'b1;
      #1;
      check_quiet("t1_rst");
      step();
      #1;
      check_quiet("t1_rst_edge");
      rst = 1'b0;
      req_valid = '0;
      fifo_full = 1'b0;
      for (int c = 0; c < 3; c++) begin
         #1;
         check("t1_idle_wr", 32'(fifo_wr_en), 32'd0);
         check("t1_idle_ga", 32'(grant_active), 32'd0);
         step();
      end

      // 2: single requester, bursts split by one IDLE cycle
      src[2] = 8'h20;
      for (int c = 0; c < 10; c++) begin
         req_valid = (src[2] < 8'h26) ? 4'b0100 : 4'b0000;
         #1;
         check("t2_wr",  32'(fifo_wr_en), 32'(t2_wr[c]));
         check("t2_din", 32'(fifo_din), 32'(t2_din[c]));
         check("t2_ga",  32'(grant_active), 32'(t2_ga[c]));
         if (t2_ga[c] == 1) check("t2_gid", 32'(grant_id), 32'd2);
         step();
      end

      // 3: all requesters valid, strict rotation of 4-beat bursts
      do_reset();
      for (int i = 0; i < NR; i++) src[i] = 8'(i * 16);
      req_valid = 4'hF;
      for (int k = 0; k < 25; k++) begin
         #1;
         p = k % 5;
         b = k / 5;
         r = b % 4;
         if (p == 0) begin
            check("t3_idle_wr", 32'(fifo_wr_en), 32'd0);
            check("t3_idle_ga", 32'(grant_active), 32'd0);
         end else begin
            check("t3_wr",    32'(fifo_wr_en), 32'd1);
            check("t3_gid",   32'(grant_id), 32'(r));
            check("t3_ready", 32'(req_ready), 32'(1 << r));
            check("t3_din",   32'(fifo_din), 32'(r * 16 + (b / 4) * 4 + p - 1));
         end
         step();
      end

      // 4: backpressure stall after two beats
      req_valid = '0;
      do_reset();
      src[0] = 8'h40;
      req_valid = 4'b0001;
      for (int c = 0; c < 9; c++) begin
         fifo_full = 1'(t4_full[c]);
         #1;
         check("t4_wr",     32'(fifo_wr_en), 32'(t4_wr[c]));
         check("t4_din",    32'(fifo_din), 32'(t4_din[c]));
         check("t4_ready0", 32'(req_ready[0]), 32'(t4_wr[c]));
         if (c >= 3 && c <= 5) check("t4_beat_cnt", 32'(dut.beat_cnt_q), 32'd2);
         step();
      end
      req_valid = '0;
      fifo_full = 1'b0;

      // 5: voluntary release moves the pointer past the releasing requester
      do_reset();
      src[1] = 8'h50;
      src[3] = 8'h70;
      req_valid = 4'b0010;
      #1; step();
      #1; check("t5_gid", 32'(grant_id), 32'd1);
      check("t5_b0", 32'(fifo_din), 32'h50);
      step();
      #1; check("t5_b1", 32'(fifo_din), 32'h51);
      step();
      req_valid = 4'b1000;
      #1;
      check("t5_rel_wr", 32'(fifo_wr_en), 32'd0);
      check("t5_rel_ga", 32'(grant_active), 32'd1);
      step();
      req_valid = 4'b1010;
      #1;
      check("t5_rr_ptr", 32'(dut.rr_ptr_q), 32'd2);
      check("t5_idle_ga", 32'(grant_active), 32'd0);
      step();
      #1;
      check("t5_next_gid", 32'(grant_id), 32'd3);
      check("t5_next_rdy", 32'(req_ready), 32'b1000);
      check("t5_next_din", 32'(fifo_din), 32'h70);
      step();

      // 6: reset during beat 3 abandons the burst
      req_valid = '0;
      do_reset();
      src[2] = 8'h60;
      req_valid = 4'b0100;
      #1; step();
      #1; step();
      #1; step();
      #1;
      check("t6_beat3", 32'(fifo_din), 32'h62);
      rst = 1'b1;
      #1;
      check_quiet("t6_rst");
      step();
      #1;
      check("t6_rst_edge_wr", 32'(fifo_wr_en), 32'd0);
      rst = 1'b0;
      req_valid = 4'hF;
      for (int i = 0; i < NR; i++) src[i] = 8'(i * 16 + 8);
      #1;
      check("t6_idle_ga", 32'(grant_active), 32'd0);
      check("t6_idle_wr", 32'(fifo_wr_en), 32'd0);
      step();
      #1;
      check("t6_gid",  32'(grant_id), 32'd0);
      check("t6_ga",   32'(grant_active), 32'd1);
      check("t6_beat", 32'(dut.beat_cnt_q), 32'd0);
      check("t6_din",  32'(fifo_din), 32'h08);
      step();

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

endmodule
